mips_multicycle_sequencer: RTL and testbench

//  Parametrised successor to the fixed FETCH/EXEC1/EXEC2/HALT controller of the multi-cycle MIPS core.

---
 rtl/mips_multicycle_sequencer.sv | 169 ++++++++++++++++
 tb/tb_mips_multicycle_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// mips_multicycle_sequencer
//   Control sequencer for the multi-cycle MIPS core. Each instruction takes one
//   FETCH cycle followed by 1..MAX_EXEC EXEC cycles. Decode supplies the EXEC
//   length, which is sampled when FETCH completes. Waitrequest stalls the
//   current state, and halt parks the sequencer in HALT. The block also keeps
//   retire and stall statistics.
//
//   Optional feature: define SEQ_WATCHDOG_EN to enable a waitrequest watchdog.
//   After TIMEOUT consecutive stalled cycles it drops into FAULT, which is
//   absorbing until reset. Without the macro o_fault is tied to 0.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          synchronous reset, active low
//   i_halt         halt request from decode
//   i_waitrequest  memory busy, stalls FETCH/EXEC
//   i_exec_len     EXEC cycles for the instruction being fetched (0 -> 1, clamped)
//   o_phase        00 FETCH, 01 EXEC, 11 HALT, 10 FAULT
//   o_exec_idx     0-based EXEC cycle index, 0 outside EXEC
//   o_last_exec    combinational: final EXEC cycle of the instruction
//   o_retire       one-cycle pulse after the last EXEC cycle completes
//   o_instr_count  retired instructions, wraps
//   o_stall_count  stalled FETCH/EXEC cycles, saturates
//   o_fault        watchdog tripped
// ---------------------------------------------------------------------------
module mips_multicycle_sequencer #(
    parameter int MAX_EXEC = 4,
    parameter int IDX_W    = 2,
    parameter int CNT_W    = 32,
    parameter int TIMEOUT  = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_halt,
    input  logic             i_waitrequest,
    input  logic [IDX_W-1:0] i_exec_len,
    output logic [1:0]       o_phase,
    output logic [IDX_W-1:0] o_exec_idx,
    output logic             o_last_exec,
    output logic             o_retire,
    output logic [CNT_W-1:0] o_instr_count,
    output logic [CNT_W-1:0] o_stall_count,
    output logic             o_fault
);

    // The latched length must be able to hold MAX_EXEC itself.
    localparam int LEN_W = $clog2(MAX_EXEC + 1);

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_EXEC  = 2'b01,
        S_FAULT = 2'b10,
        S_HALT  = 2'b11
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [LEN_W-1:0]   r_len, w_len_nxt;
    logic               r_retire, w_retire_nxt;
    logic [CNT_W-1:0]   r_icnt, r_scnt;
    logic               w_icnt_inc, w_scnt_inc;
    logic [LEN_W-1:0]   w_len_clamped;
    logic               w_last;
    logic               w_active;

`ifdef SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0]    r_wd, w_wd_nxt;
    logic               w_wd_trip;
    assign w_wd_trip = (32'(r_wd) == TIMEOUT - 1);
`endif

    // A zero length still needs one EXEC cycle. Lengths above MAX_EXEC are capped.
    always_comb begin
        w_len_clamped = LEN_W'(i_exec_len);
        if (i_exec_len == '0)
            w_len_clamped = LEN_W'(1);
        else if (32'(i_exec_len) > MAX_EXEC)
            w_len_clamped = LEN_W'(MAX_EXEC);
    end

    assign w_active = (r_state == S_FETCH) || (r_state == S_EXEC);
    assign w_last   = (r_state == S_EXEC) && (32'(r_idx) + 32'd1 == 32'(r_len));

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_len_nxt    = r_len;
        w_retire_nxt = 1'b0;
        w_icnt_inc   = 1'b0;
        w_scnt_inc   = 1'b0;
`ifdef SEQ_WATCHDOG_EN
        w_wd_nxt     = r_wd;
`endif
        if (w_active) begin
            if (i_halt) begin
                // Halt beats waitrequest and abandons the instruction unretired.
                w_state_nxt = S_HALT;
                w_idx_nxt   = '0;
            end else if (i_waitrequest) begin
                w_scnt_inc = 1'b1;
`ifdef SEQ_WATCHDOG_EN
                if (w_wd_trip) begin
                    w_state_nxt = S_FAULT;
                    w_idx_nxt   = '0;
                end else begin
                    w_wd_nxt = r_wd + 1'b1;
                end
`endif
            end else begin
`ifdef SEQ_WATCHDOG_EN
                w_wd_nxt = '0;
`endif
                if (r_state == S_FETCH) begin
                    w_len_nxt   = w_len_clamped;
                    w_state_nxt = S_EXEC;
                    w_idx_nxt   = '0;
                end else if (w_last) begin
                    w_state_nxt  = S_FETCH;
                    w_idx_nxt    = '0;
                    w_retire_nxt = 1'b1;
                    w_icnt_inc   = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state  <= i_halt ? S_HALT : S_FETCH;
            r_idx    <= '0;
            r_len    <= LEN_W'(1);
            r_retire <= 1'b0;
            r_icnt   <= '0;
            r_scnt   <= '0;
`ifdef SEQ_WATCHDOG_EN
            r_wd     <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_len    <= w_len_nxt;
            r_retire <= w_retire_nxt;
            if (w_icnt_inc)
                r_icnt <= r_icnt + 1'b1;
            if (w_scnt_inc && (r_scnt != '1))
                r_scnt <= r_scnt + 1'b1;
`ifdef SEQ_WATCHDOG_EN
            r_wd     <= w_wd_nxt;
`endif
        end
    end

    assign o_phase       = r_state;
    assign o_exec_idx    = r_idx;
    assign o_last_exec   = w_last;
    assign o_retire      = r_retire;
    assign o_instr_count = r_icnt;
    assign o_stall_count = r_scnt;
`ifdef SEQ_WATCHDOG_EN
    assign o_fault       = (r_state == S_FAULT);
`else
    assign o_fault       = 1'b0;
`endif

endmodule

// File: tb/tb_mips_multicycle_sequencer.sv
module tb_mips_multicycle_sequencer;

    localparam int MAX_EXEC = 4;
    localparam int IDX_W    = 3;
    localparam int CNT_W    = 4;
    localparam int TIMEOUT  = 4;
`ifdef SEQ_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, halt, wr;
    logic [IDX_W-1:0] len;
    logic [1:0]       phase;
    logic [IDX_W-1:0] idx;
    logic             last, retire, fault;
    logic [CNT_W-1:0] icnt, scnt;

    int total = 0;
    int bad   = 0;

    mips_multicycle_sequencer #(
        .MAX_EXEC(MAX_EXEC), .IDX_W(IDX_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_halt(halt), .i_waitrequest(wr),
        .i_exec_len(len), .o_phase(phase), .o_exec_idx(idx),
        .o_last_exec(last), .o_retire(retire), .o_instr_count(icnt),
        .o_stall_count(scnt), .o_fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input bit r, input bit h, input bit w, input int l);
        rst = r; halt = h; wr = w; len = IDX_W'(l);
        tick();
    endtask

    // Reference model. It tracks the instruction abstractly: whether it is
    // executing, how many EXEC cycles are done, and the sticky halted/faulted flags.
    bit m_halted, m_faulted, m_in_exec, m_retire;
    int m_done, m_len, m_ic, m_sc, m_wd;

    task automatic model_step(input bit r, input bit h, input bit w, input int l);
        m_retire = 1'b0;
        if (!r) begin
            m_halted = h; m_faulted = 1'b0; m_in_exec = 1'b0;
            m_done = 0; m_len = 1; m_ic = 0; m_sc = 0; m_wd = 0;
        end else if (m_halted || m_faulted) begin
            // absorbing
        end else if (h) begin
            m_halted = 1'b1; m_in_exec = 1'b0; m_done = 0;
        end else if (w) begin
            m_sc = (m_sc == (1 << CNT_W) - 1) ? m_sc : m_sc + 1;
            if (WD_ON && m_wd == TIMEOUT - 1) begin
                m_faulted = 1'b1; m_in_exec = 1'b0; m_done = 0;
            end else begin
                m_wd++;
            end
        end else begin
            m_wd = 0;
            if (!m_in_exec) begin
                m_len = (l == 0) ? 1 : (l > MAX_EXEC ? MAX_EXEC : l);
                m_in_exec = 1'b1; m_done = 0;
            end else begin
                m_done++;
                if (m_done == m_len) begin
                    m_in_exec = 1'b0; m_done = 0; m_retire = 1'b1;
                    m_ic = (m_ic + 1) % (1 << CNT_W);
                end
            end
        end
    endtask

    typedef struct {
        bit r, h, w; int l;
        int ph, ix; bit lst, ret;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int cyc;
        int eph, eix;
        bit elst;
        rst = 1'b0; halt = 1'b0; wr = 1'b0; len = '0;

        vecs[0]  = '{0,1,0,0, 3,0,0,0};
        vecs[1]  = '{0,0,0,0, 0,0,0,0};
        vecs[2]  = '{1,0,0,1, 1,0,1,0};
        vecs[3]  = '{1,0,0,1, 0,0,0,1};
        vecs[4]  = '{1,0,0,1, 1,0,1,0};
        vecs[5]  = '{1,0,0,1, 0,0,0,1};
        vecs[6]  = '{1,0,0,3, 1,0,0,0};
        vecs[7]  = '{1,0,0,3, 1,1,0,0};
        vecs[8]  = '{1,0,0,3, 1,2,1,0};
        vecs[9]  = '{1,0,0,3, 0,0,0,1};
        vecs[10] = '{1,0,0,0, 1,0,1,0};
        vecs[11] = '{1,0,0,0, 0,0,0,1};
        vecs[12] = '{1,0,0,7, 1,0,0,0};
        vecs[13] = '{1,0,0,7, 1,1,0,0};
        vecs[14] = '{1,0,0,7, 1,2,0,0};
        vecs[15] = '{1,0,0,7, 1,3,1,0};
        vecs[16] = '{1,0,0,7, 0,0,0,1};

        for (int i = 0; i < 17; i++) begin
            apply(vecs[i].r, vecs[i].h, vecs[i].w, vecs[i].l);
            chk($sformatf("vec%0d phase", i), phase, vecs[i].ph);
            chk($sformatf("vec%0d idx", i), idx, vecs[i].ix);
            chk($sformatf("vec%0d last", i), last, vecs[i].lst);
            chk($sformatf("vec%0d retire", i), retire, vecs[i].ret);
            if (i == 1) begin
                chk("reset icnt", icnt, 0);
                chk("reset scnt", scnt, 0);
                chk("reset fault", fault, 0);
            end
        end
        chk("icnt after table", icnt, 5);
        chk("scnt after table", scnt, 0);

        // Stall latency: two FETCH stalls and three EXEC idx1 stalls.
        apply(0, 0, 0, 0);
        cyc = 0;
        for (int e = 1; e <= 20 && !retire; e++) begin
            apply(1, 0, (e <= 2) || (e >= 5 && e <= 7), 2);
            cyc = e;
        end
        chk("stall instr cycles", cyc, 8);
        chk("stall count", scnt, 5);
        chk("stall icnt", icnt, 1);

        // Halt during a stalled EXEC cycle.
        apply(0, 0, 0, 0);
        apply(1, 0, 0, 3);
        chk("pre-halt phase", phase, 1);
        apply(1, 1, 1, 3);
        chk("halt phase", phase, 3);
        chk("halt no retire", retire, 0);
        chk("halt idx", idx, 0);
        apply(1, 0, 0, 3);
        chk("halt sticky", phase, 3);
        apply(0, 1, 0, 0);
        chk("reset into halt", phase, 3);
        apply(0, 0, 0, 0);
        chk("reset out of halt", phase, 0);
        chk("halt icnt", icnt, 0);

        // Counter wrap with single-cycle instructions.
        for (int i = 0; i < 34; i++) apply(1, 0, 0, 0);
        chk("icnt wrap", icnt, 17 % (1 << CNT_W));

`ifdef SEQ_WATCHDOG_EN
        apply(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) apply(1, 0, 1, 1);
        chk("wd phase", phase, 2);
        chk("wd fault", fault, 1);
        apply(1, 0, 0, 1);
        chk("wd sticky", phase, 2);
        apply(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) apply(1, 0, 1, 1);
        apply(1, 0, 0, 1);
        chk("wd no trip phase", phase, 1);
        chk("wd no trip fault", fault, 0);
`else
        // Stall saturation, which cannot be reached when the watchdog is enabled.
        apply(0, 0, 0, 0);
        for (int i = 0; i < 20; i++) apply(1, 0, 1, 1);
        chk("scnt saturate", scnt, (1 << CNT_W) - 1);
        chk("no fault", fault, 0);
`endif

        // Randomized run against the model.
        apply(0, 0, 0, 0);
        model_step(0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            bit r, h, w;
            int l;
            r = ($urandom_range(0, 63) != 0);
            h = ($urandom_range(0, 49) == 0);
            w = ($urandom_range(0, 3) == 0);
            l = $urandom_range(0, 7);
            apply(r, h, w, l);
            model_step(r, h, w, l);
            eph  = m_halted ? 3 : (m_faulted ? 2 : (m_in_exec ? 1 : 0));
            eix  = m_in_exec ? m_done : 0;
            elst = m_in_exec && (m_done == m_len - 1);
            if (phase != eph || idx != eix || last != elst || retire != m_retire ||
                icnt != m_ic || scnt != m_sc || fault != m_faulted) begin
                total++;
                bad++;
                $display("FAIL rand%0d: got ph=%0d ix=%0d l=%0d r=%0d ic=%0d sc=%0d f=%0d expected ph=%0d ix=%0d l=%0d r=%0d ic=%0d sc=%0d f=%0d",
                         i, phase, idx, last, retire, icnt, scnt, fault,
                         eph, eix, elst, m_retire, m_ic, m_sc, m_faulted);
            end else begin
                total++;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
